// File: rtl/upr_play_ctrl.sv
// upr_play_ctrl - UART-configured sequencer for the ROM sample-playback path.
// Framed packets (A5, CMD, D3..D0, CS) set the phase step, loop bounds and run
// state; a 32-bit phase accumulator issues ROM addresses, and returned samples
// are registered for the TX datapath.
// Build option: define UPR_GAIN_EN to add the 8-bit output gain (CMD 0x05),
// which costs one extra pipeline stage on data_out/data_vld.
//
// Parser states:
//   S_IDLE | waiting for 0xA5 sync byte
//   S_CMD  | next byte is the command
//   S_DATA | collecting D3..D0, MSB first
//   S_CS   | next byte is the checksum
//   S_EXEC | one cycle, command applied

module upr_play_ctrl #(
    parameter logic [15:0] MAX_ADR  = 16'd12586,
    parameter logic [31:0] DEF_STEP = 32'd477901,
    parameter int          TIMEOUT  = 100000,
    parameter int          ROM_LAT  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  uart_in,
    input  logic        uart_rcv,
    input  logic        btn,
    input  logic [15:0] rom_in,
    output logic [15:0] adr_rom,
    output logic [31:0] data_out,
    output logic        data_vld,
    output logic        running,
    output logic        err,
    output logic        tst
);
    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_DATA, S_CS, S_EXEC} state_t;
    state_t state, state_nxt;

    logic [7:0]    cmd_q;
    logic [31:0]   data_q;
    logic [1:0]    byte_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [7:0]    cs_calc;
    logic          cmd_ok;
    logic          tmo_hit;
    logic          pkt_err;
    logic          exec;

    logic [31:0]   step;
    logic [15:0]   start_adr;
    logic [15:0]   end_adr;
    logic [31:0]   acc;
    logic          run;
    logic          run_nxt;
    logic [2:0]    btn_sync;
    logic          btn_rel;
    logic [32:0]   sum;
    logic          tick;
    logic          wrap;
    logic [ROM_LAT:0] tick_pipe;

    assign cs_calc = cmd_q ^ data_q[31:24] ^ data_q[23:16] ^ data_q[15:8] ^ data_q[7:0];
    assign exec    = (state == S_EXEC);
`ifdef UPR_GAIN_EN
    assign cmd_ok  = (cmd_q >= 8'h01) && (cmd_q <= 8'h05);
`else
    assign cmd_ok  = (cmd_q >= 8'h01) && (cmd_q <= 8'h04);
`endif
    // The EXEC cycle is never waiting on the UART, so it is exempt from timeout
    assign tmo_hit = ((state == S_CMD) || (state == S_DATA) || (state == S_CS))
                     && !uart_rcv && (tmo_cnt == '0);

    // Parser state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Parser next-state and error decode
    always_comb begin
        state_nxt = state;
        pkt_err   = 1'b0;
        case (state)
            S_IDLE: if (uart_rcv && (uart_in == 8'hA5)) state_nxt = S_CMD;
            S_CMD:  if (uart_rcv) state_nxt = S_DATA;
            S_DATA: if (uart_rcv && (byte_cnt == 2'd3)) state_nxt = S_CS;
            S_CS: begin
                if (uart_rcv) begin
                    if (uart_in == cs_calc) begin
                        state_nxt = S_EXEC;
                    end else begin
                        state_nxt = S_IDLE;
                        pkt_err   = 1'b1;
                    end
                end
            end
            S_EXEC: begin
                state_nxt = S_IDLE;
                if (!cmd_ok) pkt_err = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (tmo_hit) begin
            state_nxt = S_IDLE;
            pkt_err   = 1'b1;
        end
    end

    // Packet capture and inter-byte timeout down-counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_q    <= '0;
            data_q   <= '0;
            byte_cnt <= '0;
            tmo_cnt  <= TMO_LOAD;
            err      <= 1'b0;
        end else begin
            err <= pkt_err;
            if ((state == S_IDLE) || uart_rcv) tmo_cnt <= TMO_LOAD;
            else if (tmo_cnt != '0)            tmo_cnt <= tmo_cnt - TW'(1);
            if (state == S_CMD) begin
                byte_cnt <= '0;
                if (uart_rcv) cmd_q <= uart_in;
            end
            if ((state == S_DATA) && uart_rcv) begin
                data_q   <= {data_q[23:0], uart_in};
                byte_cnt <= byte_cnt + 2'd1;
            end
        end
    end

    // Configuration registers written from EXEC
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step      <= DEF_STEP;
            start_adr <= '0;
            end_adr   <= MAX_ADR;
        end else if (exec) begin
            if (cmd_q == 8'h01) step      <= data_q;
            if (cmd_q == 8'h02) start_adr <= data_q[15:0];
            if (cmd_q == 8'h03) end_adr   <= data_q[15:0];
        end
    end

    // Button: two-flop synchroniser plus one delay flop for release detect
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) btn_sync <= '0;
        else      btn_sync <= {btn_sync[1:0], btn};
    end
    assign btn_rel = btn_sync[2] & ~btn_sync[1];

    // A run command overrides a simultaneous button toggle
    always_comb begin
        run_nxt = run;
        if (exec && (cmd_q == 8'h04)) run_nxt = data_q[0];
        else if (btn_rel)             run_nxt = ~run;
    end

    assign sum  = {1'b0, acc} + {1'b0, step};
    assign tick = run && run_nxt && sum[32];
    assign wrap = (adr_rom >= end_adr) || (adr_rom < start_adr);

    // Run state, phase accumulator and address generation
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run     <= 1'b0;
            acc     <= '0;
            adr_rom <= '0;
        end else begin
            run <= run_nxt;
            if (run_nxt && !run) begin
                acc     <= '0;
                adr_rom <= start_adr;
            end else if (!run_nxt) begin
                acc <= '0;
            end else begin
                acc <= sum[31:0];
                if (sum[32]) adr_rom <= wrap ? start_adr : adr_rom + 16'd1;
            end
        end
    end

    // Track each tick until its ROM word is on rom_in
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tick_pipe <= '0;
        else      tick_pipe <= {tick_pipe[ROM_LAT-1:0], tick};
    end

`ifdef UPR_GAIN_EN
    logic [7:0]  gain;
    logic [23:0] prod_q;
    logic        prod_vld;

    // Gain register written from EXEC
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                          gain <= 8'd11;
        else if (exec && (cmd_q == 8'h05)) gain <= data_q[7:0];
    end

    // Multiply stage followed by the output register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod_q   <= '0;
            prod_vld <= 1'b0;
            data_out <= '0;
            data_vld <= 1'b0;
        end else begin
            prod_vld <= tick_pipe[ROM_LAT];
            if (tick_pipe[ROM_LAT]) prod_q <= 24'(rom_in) * 24'(gain);
            data_vld <= prod_vld;
            if (prod_vld) data_out <= {8'h00, prod_q};
        end
    end
`else
    // Output register captures the ROM word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out <= '0;
            data_vld <= 1'b0;
        end else begin
            data_vld <= tick_pipe[ROM_LAT];
            if (tick_pipe[ROM_LAT]) data_out <= {16'h0000, rom_in};
        end
    end
`endif

    assign running = run;
    assign tst     = acc[31];

endmodule
